idli_io_bank_m: RTL and testbench

Parametrised nibble-serial I/O register bank: `NUM_REGS` registers of `REG_NIBBLES` nibbles each. Every register is read or written 4 bits per cycle over a shared nibble bus in fixed-length transfers. It is the next generation of the single 16-bit I/O register. Registers no longer rotate continuously; they hold their value at rest, and a beat counter picks the nibble. Sits between the core's nibble datapath and the memory-mapped I/O space.

---
 rtl/idli_io_bank_m.sv | 151 +++++++++++++++
 tb/tb_idli_io_bank_m.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/idli_io_bank_m.sv
// rtl/idli_io_bank_m.sv - nibble-serial I/O register bank
//
// NUM_REGS registers of REG_NIBBLES nibbles each. A register is read or
// written one nibble per cycle over a shared 4-bit bus in fixed-length
// transfers of REG_NIBBLES beats. Beat 0 is the start cycle and nibble 0
// (least significant) goes first.
//
// Optional feature macro: IDLI_IO_BANK_PINS_EN adds o_io_pins, a shadow copy
// of every register that only updates once a write transfer has completed.
//
// Ports:
//   i_io_gck    clock, rising edge
//   i_io_rst_n  asynchronous active-low reset
//   i_io_start  begin a transfer (sampled only in IDLE)
//   i_io_sel    register index (sampled with i_io_start)
//   i_io_wr     1 = write, 0 = read (sampled with i_io_start)
//   i_io_data   write nibble for the current beat
//   o_io_data   read nibble for the current beat, 0 otherwise
//   o_io_busy   high while in XFER
//   o_io_done   high on the last beat of a transfer
//   o_io_pins   (IDLI_IO_BANK_PINS_EN only) shadow copy of all registers
module idli_io_bank_m #(
  parameter int NUM_REGS    = 4,
  parameter int REG_NIBBLES = 4,
  localparam int SW = $clog2(NUM_REGS),
  localparam int CW = $clog2(REG_NIBBLES)
) (
  input  logic          i_io_gck,
  input  logic          i_io_rst_n,
  input  logic          i_io_start,
  input  logic [SW-1:0] i_io_sel,
  input  logic          i_io_wr,
  input  logic [3:0]    i_io_data,
  output logic [3:0]    o_io_data,
  output logic          o_io_busy,
  output logic          o_io_done
`ifdef IDLI_IO_BANK_PINS_EN
  ,
  output logic [NUM_REGS*REG_NIBBLES*4-1:0] o_io_pins
`endif
);

  localparam int RW = REG_NIBBLES * 4;
  localparam logic [CW-1:0] LAST = CW'(REG_NIBBLES - 1);
  localparam logic [SW:0]   NREG = (SW + 1)'(NUM_REGS);

  typedef enum logic {IDLE, XFER} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            wr_q, wr_d;
  logic [RW-1:0]   regs_q [NUM_REGS];
  logic [RW-1:0]   regs_d [NUM_REGS];

  // Beat context: live inputs on beat 0, latched copies afterwards.
  logic            active;
  logic [CW-1:0]   cur_beat;
  logic [SW-1:0]   cur_sel;
  logic            cur_wr;
  logic            in_range;
  logic [CW+1:0]   bit_ofs;

  always_ff @(posedge i_io_gck or negedge i_io_rst_n) begin
    if (!i_io_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    regs_d    = regs_q;
    active    = 1'b0;
    cur_beat  = '0;
    cur_sel   = i_io_sel;
    cur_wr    = i_io_wr;
    o_io_data = 4'h0;

    case (state_q)
      IDLE: begin
        if (i_io_start) begin
          active  = 1'b1;
          state_d = XFER;
          beat_d  = CW'(1);
          sel_d   = i_io_sel;
          wr_d    = i_io_wr;
        end
      end
      XFER: begin
        active   = 1'b1;
        cur_beat = beat_q;
        cur_sel  = sel_q;
        cur_wr   = wr_q;
        if (beat_q == LAST) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Out-of-range selects still run the full transfer but touch nothing.
    in_range = ({1'b0, cur_sel} < NREG);
    bit_ofs  = {cur_beat, 2'b00};

    if (active && in_range) begin
      if (cur_wr) begin
        regs_d[cur_sel][bit_ofs +: 4] = i_io_data;
      end else begin
        o_io_data = regs_q[cur_sel][bit_ofs +: 4];
      end
    end
  end

  assign o_io_busy = (state_q == XFER);
  assign o_io_done = (state_q == XFER) && (beat_q == LAST);

`ifdef IDLI_IO_BANK_PINS_EN
  logic [RW-1:0] shadow_q [NUM_REGS];

  // Capture the completed value at the done edge so the pins never show a
  // half-written register; visible from the cycle after done.
  always_ff @(posedge i_io_gck or negedge i_io_rst_n) begin
    if (!i_io_rst_n) begin
      shadow_q <= '{default: '0};
    end else if (o_io_done && wr_q && in_range) begin
      shadow_q[sel_q] <= regs_d[sel_q];
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pins
    assign o_io_pins[r*RW +: RW] = shadow_q[r];
  end
`endif

endmodule

// File: tb/tb_idli_io_bank_m.sv
// tb/tb_idli_io_bank_m.sv - self-checking bench for idli_io_bank_m
module tb_idli_io_bank_m;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default 4 x 4
  logic        a_start, a_wr;
  logic [1:0]  a_sel;
  logic [3:0]  a_din, a_dout;
  logic        a_busy, a_done;
`ifdef IDLI_IO_BANK_PINS_EN
  logic [63:0] a_pins;
`endif

  // Instance B: 3 registers x 8 nibbles (select 3 is out of range)
  logic        b_start, b_wr;
  logic [1:0]  b_sel;
  logic [3:0]  b_din, b_dout;
  logic        b_busy, b_done;
`ifdef IDLI_IO_BANK_PINS_EN
  logic [95:0] b_pins;
`endif

  idli_io_bank_m u_a (
    .i_io_gck(clk), .i_io_rst_n(rst_n), .i_io_start(a_start), .i_io_sel(a_sel),
    .i_io_wr(a_wr), .i_io_data(a_din), .o_io_data(a_dout), .o_io_busy(a_busy),
    .o_io_done(a_done)
`ifdef IDLI_IO_BANK_PINS_EN
    , .o_io_pins(a_pins)
`endif
  );

  idli_io_bank_m #(.NUM_REGS(3), .REG_NIBBLES(8)) u_b (
    .i_io_gck(clk), .i_io_rst_n(rst_n), .i_io_start(b_start), .i_io_sel(b_sel),
    .i_io_wr(b_wr), .i_io_data(b_din), .o_io_data(b_dout), .o_io_busy(b_busy),
    .o_io_done(b_done)
`ifdef IDLI_IO_BANK_PINS_EN
    , .o_io_pins(b_pins)
`endif
  );

  // Reference model: register contents as whole words.
  logic [15:0] ma [4];
  logic [31:0] mb [3];
  logic [15:0] sa [4];   // pin shadow model for A

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 4; i++) begin ma[i] = '0; sa[i] = '0; end
    for (int i = 0; i < 3; i++) mb[i] = '0;
  endtask

  // One full transfer on A. Beats after 0 drive junk sel/wr and may hold
  // start high, all of which must be ignored.
  task automatic xfer_a(input int sel, input bit wr, input logic [15:0] wd);
    logic [3:0] exp_nib;
    for (int k = 0; k < 4; k++) begin
      a_start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a_sel   = (k == 0) ? 2'(sel) : 2'($urandom);
      a_wr    = (k == 0) ? wr : 1'($urandom);
      a_din   = wd[k*4 +: 4];
      @(negedge clk);
      exp_nib = wr ? 4'h0 : ma[sel][k*4 +: 4];
      chk("a_busy", 64'(a_busy), 64'(k != 0));
      chk("a_done", 64'(a_done), 64'(k == 3));
      chk("a_rdata", 64'(a_dout), 64'(exp_nib));
`ifdef IDLI_IO_BANK_PINS_EN
      chk("a_pins_hold", a_pins, {sa[3], sa[2], sa[1], sa[0]});
`endif
      @(posedge clk); #1;
    end
    a_start = 1'b0;
    if (wr) begin ma[sel] = wd; sa[sel] = wd; end
`ifdef IDLI_IO_BANK_PINS_EN
    chk("a_pins_upd", a_pins, {sa[3], sa[2], sa[1], sa[0]});
`endif
  endtask

  task automatic xfer_b(input int sel, input bit wr, input logic [31:0] wd);
    logic [3:0] exp_nib;
    for (int k = 0; k < 8; k++) begin
      b_start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      b_sel   = (k == 0) ? 2'(sel) : 2'($urandom);
      b_wr    = (k == 0) ? wr : 1'($urandom);
      b_din   = wd[k*4 +: 4];
      @(negedge clk);
      exp_nib = (wr || sel >= 3) ? 4'h0 : mb[sel][k*4 +: 4];
      chk("b_busy", 64'(b_busy), 64'(k != 0));
      chk("b_done", 64'(b_done), 64'(k == 7));
      chk("b_rdata", 64'(b_dout), 64'(exp_nib));
      @(posedge clk); #1;
    end
    b_start = 1'b0;
    if (wr && sel < 3) mb[sel] = wd;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("a_idle_busy", 64'(a_busy), 64'd0);
    chk("a_idle_done", 64'(a_done), 64'd0);
    chk("a_idle_data", 64'(a_dout), 64'd0);
    chk("b_idle_busy", 64'(b_busy), 64'd0);
    chk("b_idle_data", 64'(b_dout), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_sel = '0; a_wr = 1'b0; a_din = '0;
    b_start = 1'b0; b_sel = '0; b_wr = 1'b0; b_din = '0;
    clear_models();
    repeat (2) @(posedge clk);
    idle_check();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check();

    // Every register reads zero after reset.
    for (int r = 0; r < 4; r++) xfer_a(r, 1'b0, 16'h0);

    // Nibbles D,A,E,B into reg 2, least significant first.
    xfer_a(2, 1'b1, 16'hBEAD);
    for (int r = 0; r < 4; r++) xfer_a(r, 1'b0, 16'h0);

    // Shadow/pins update for a 0xBEEF write to reg 1.
    xfer_a(1, 1'b1, 16'hBEEF);
    xfer_a(1, 1'b0, 16'h0);

    // Randomised transfers, sometimes back to back, sometimes with gaps.
    for (int n = 0; n < 60; n++) begin
      xfer_a(int'($urandom_range(0, 3)), 1'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    // Out-of-range select on the 3 x 8 instance.
    xfer_b(3, 1'b1, 32'hFFFF_FFFF);
    xfer_b(3, 1'b0, 32'h0);
    xfer_b(2, 1'b1, 32'h89AB_CDEF);
    for (int r = 0; r < 4; r++) xfer_b(r, 1'b0, 32'h0);
    for (int n = 0; n < 20; n++)
      xfer_b(int'($urandom_range(0, 3)), 1'($urandom), $urandom);

    // Reset in the middle of a 0x1234 write to reg 0.
    a_start = 1'b1; a_sel = 2'd0; a_wr = 1'b1; a_din = 4'h4;
    @(posedge clk); #1;
    a_start = 1'b0; a_din = 4'h3;
    @(posedge clk); #1;
    a_din = 4'h2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_data", 64'(a_dout), 64'd0);
    clear_models();
`ifdef IDLI_IO_BANK_PINS_EN
    chk("rst_pins", a_pins, 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check();
    for (int r = 0; r < 4; r++) xfer_a(r, 1'b0, 16'h0);
    for (int r = 0; r < 3; r++) xfer_b(r, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
